// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - keypad calculator controller sequencing operand entry and an external ALU
//
// Ports:
//   clock_i        system clock, all state on rising edge
//   reset_i        synchronous active-high reset
//   cmd_i          keypad command: 0-9 digit, A add, B sub, C mul, D clear-entry, E equals, F clear-all
//   cmd_valid_i    command present; accepted when cmd_valid_i && cmd_ready_o
//   cmd_ready_o    low only while an ALU operation is in flight
//   alu_start_o    one-cycle ALU launch pulse
//   alu_op_o       00 add, 01 sub, 10 mul
//   alu_a_o        operand A (held until alu_done_i)
//   alu_b_o        operand B (held until alu_done_i)
//   alu_done_i     one-cycle result-valid pulse
//   alu_result_i   ALU result, valid with alu_done_i
//   alu_ovf_i      result out of display range, valid with alu_done_i
//   digits_o       value to display
//   status_o       00 ENTRY, 01 BUSY, 10 RESULT, 11 ERROR
//
// Optional feature: define CALC_CHAIN_EN so that an operator typed after B
// digits evaluates the pending operation and continues with the new operator.
module calc_ctrl (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [3:0]  cmd_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic        alu_start_o,
  output logic [1:0]  alu_op_o,
  output logic [26:0] alu_a_o,
  output logic [26:0] alu_b_o,
  input  logic        alu_done_i,
  input  logic [26:0] alu_result_i,
  input  logic        alu_ovf_i,
  output logic [26:0] digits_o,
  output logic [1:0]  status_o
);

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_BUSY,
    S_RESULT,
    S_ERROR
  } state_t;

  // An entry at or above this value already has eight digits.
  localparam logic [26:0] ENTRY_LIMIT = 27'd10000000;

  state_t      state_q;
  logic [26:0] entry_q;
  logic [26:0] a_q;
  logic [26:0] digits_q;
  logic [1:0]  op_q;
  logic        b_has_q;
  logic        alu_start_q;
  logic [1:0]  alu_op_q;
  logic [26:0] alu_a_q;
  logic [26:0] alu_b_q;
  logic [5:0]  wd_q;
`ifdef CALC_CHAIN_EN
  logic        chain_q;
  logic [1:0]  next_op_q;
`endif

  logic        accept;
  logic        is_digit;
  logic        is_op;
  logic        is_ce;
  logic        is_eq;
  logic        is_ca;
  logic        entry_room;
  logic [26:0] entry_d;
  logic [26:0] digit_val;
  logic [1:0]  cmd_op;

  assign accept     = cmd_valid_i && cmd_ready_o;
  assign is_digit   = (cmd_i <= 4'd9);
  assign is_op      = (cmd_i == 4'hA) || (cmd_i == 4'hB) || (cmd_i == 4'hC);
  assign is_ce      = (cmd_i == 4'hD);
  assign is_eq      = (cmd_i == 4'hE);
  assign is_ca      = (cmd_i == 4'hF);
  assign entry_room = (entry_q < ENTRY_LIMIT);
  assign digit_val  = {23'd0, cmd_i};
  assign entry_d    = entry_q * 27'd10 + digit_val;
  // A->00, B->01, C->10 falls straight out of bits 2 and 0.
  assign cmd_op     = {cmd_i[2], cmd_i[0]};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_ENTER_A;
      entry_q     <= '0;
      a_q         <= '0;
      digits_q    <= '0;
      op_q        <= '0;
      b_has_q     <= 1'b0;
      alu_start_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      wd_q        <= '0;
`ifdef CALC_CHAIN_EN
      chain_q     <= 1'b0;
      next_op_q   <= '0;
`endif
    end else begin
      alu_start_q <= 1'b0;
      case (state_q)
        S_ENTER_A, S_ENTER_B: begin
          if (accept) begin
            if (is_digit) begin
              if (entry_room) begin
                entry_q  <= entry_d;
                digits_q <= entry_d;
                if (state_q == S_ENTER_B) b_has_q <= 1'b1;
              end
            end else if (is_op) begin
              if (state_q == S_ENTER_A) begin
                a_q     <= digits_q;
                op_q    <= cmd_op;
                entry_q <= '0;
                b_has_q <= 1'b0;
                state_q <= S_ENTER_B;
              end else if (!b_has_q) begin
                op_q <= cmd_op;
              end
`ifdef CALC_CHAIN_EN
              else begin
                alu_start_q <= 1'b1;
                alu_a_q     <= a_q;
                alu_b_q     <= entry_q;
                alu_op_q    <= op_q;
                wd_q        <= '0;
                chain_q     <= 1'b1;
                next_op_q   <= cmd_op;
                state_q     <= S_BUSY;
              end
`endif
            end else if (is_ce) begin
              entry_q  <= '0;
              digits_q <= '0;
            end else if (is_eq) begin
              if (state_q == S_ENTER_B && b_has_q) begin
                alu_start_q <= 1'b1;
                alu_a_q     <= a_q;
                alu_b_q     <= entry_q;
                alu_op_q    <= op_q;
                wd_q        <= '0;
`ifdef CALC_CHAIN_EN
                chain_q     <= 1'b0;
`endif
                state_q     <= S_BUSY;
              end
            end else begin
              a_q      <= '0;
              entry_q  <= '0;
              op_q     <= '0;
              digits_q <= '0;
              b_has_q  <= 1'b0;
              state_q  <= S_ENTER_A;
            end
          end
        end

        S_BUSY: begin
          wd_q <= wd_q + 6'd1;
          // The done pulse is only meaningful once the launch cycle is over.
          if (!alu_start_q && alu_done_i) begin
            if (alu_ovf_i) begin
              digits_q <= '0;
              state_q  <= S_ERROR;
            end
`ifdef CALC_CHAIN_EN
            else if (chain_q) begin
              a_q      <= alu_result_i;
              digits_q <= alu_result_i;
              entry_q  <= '0;
              b_has_q  <= 1'b0;
              op_q     <= next_op_q;
              chain_q  <= 1'b0;
              state_q  <= S_ENTER_B;
            end
`endif
            else begin
              digits_q <= alu_result_i;
              state_q  <= S_RESULT;
            end
          end else if (wd_q == 6'd63) begin
            digits_q <= '0;
            state_q  <= S_ERROR;
          end
        end

        S_RESULT: begin
          if (accept) begin
            if (is_digit) begin
              entry_q  <= digit_val;
              digits_q <= digit_val;
              state_q  <= S_ENTER_A;
            end else if (is_op) begin
              a_q     <= digits_q;
              op_q    <= cmd_op;
              entry_q <= '0;
              b_has_q <= 1'b0;
              state_q <= S_ENTER_B;
            end else if (is_ce) begin
              entry_q  <= '0;
              digits_q <= '0;
              state_q  <= S_ENTER_A;
            end else if (is_ca) begin
              a_q      <= '0;
              entry_q  <= '0;
              op_q     <= '0;
              digits_q <= '0;
              b_has_q  <= 1'b0;
              state_q  <= S_ENTER_A;
            end
          end
        end

        S_ERROR: begin
          if (accept && is_ca) begin
            a_q      <= '0;
            entry_q  <= '0;
            op_q     <= '0;
            digits_q <= '0;
            b_has_q  <= 1'b0;
            state_q  <= S_ENTER_A;
          end
        end

        default: state_q <= S_ENTER_A;
      endcase
    end
  end

  always_comb begin
    status_o    = 2'b00;
    cmd_ready_o = 1'b1;
    case (state_q)
      S_BUSY: begin
        status_o    = 2'b01;
        cmd_ready_o = 1'b0;
      end
      S_RESULT: status_o = 2'b10;
      S_ERROR:  status_o = 2'b11;
      default:  status_o = 2'b00;
    endcase
  end

  assign alu_start_o = alu_start_q;
  assign alu_op_o    = alu_op_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign digits_o    = digits_q;

endmodule
